// File: rtl/sram_dp_port_ctrl.sv
`default_nettype none
// ============================================================================
// sram_dp_port_ctrl : valid/ready front end for a 1W/1R dual-port SRAM macro
// Rev 1.0
// ============================================================================
module sram_dp_port_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int RESP_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1,
   output logic                  busy
);

   localparam int CW = $clog2(RESP_DEPTH + 1) + 1;
   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

   logic                    wr_fire;
   logic                    rd_fire;
   logic                    hazard;
   logic                    credit_ok;
   logic                    push;
   logic                    pop;
   logic [READ_LATENCY-1:0] inflight;
   logic [CW-1:0]           inflight_count;
   logic [CW-1:0]           fifo_count;
   logic [CW-1:0]           occupancy;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [DATA_WIDTH-1:0]   fifo_mem [RESP_DEPTH];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Write port: writes are never stalled, strobes pass straight through.
   assign wr_ready   = !reset;
   assign wr_fire    = wr_valid & wr_ready;
   assign sram_csb0  = !wr_fire;
   assign sram_addr0 = wr_addr;
   assign sram_din0  = wr_data;

   // The macro leaves same-cycle same-address R/W undefined, so the read waits.
   assign hazard     = wr_fire & rd_valid & (rd_addr == wr_addr);
   assign pop        = resp_valid & resp_ready;
   assign occupancy  = fifo_count + inflight_count - CW'(pop);
   assign credit_ok  = occupancy < CW'(RESP_DEPTH);
   assign rd_ready   = !reset & credit_ok & !hazard;
   assign rd_fire    = rd_valid & rd_ready;
   assign sram_csb1  = !rd_fire;
   assign sram_addr1 = rd_addr;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight_count = inflight_count + CW'(inflight[i]);
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_pipe_single
         always_ff @(posedge clock) begin
            if (reset) inflight <= '0;
            else       inflight <= rd_fire;
         end
      end else begin : g_pipe_multi
         always_ff @(posedge clock) begin
            if (reset) inflight <= '0;
            else       inflight <= {inflight[READ_LATENCY-2:0], rd_fire};
         end
      end
   endgenerate

   // Last pipeline stage marks the cycle sram_dout1 holds valid read data.
   assign push = inflight[READ_LATENCY-1];

   always_ff @(posedge clock) begin
      if (push && !reset) fifo_mem[wr_ptr] <= sram_dout1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign resp_valid = (fifo_count != '0);
   assign resp_data  = fifo_mem[rd_ptr];
   assign busy       = (inflight_count != '0) | (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_port_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sram_dp_port_ctrl : directed bench with SRAM model and response scoreboard
// Rev 1.0
// ============================================================================
module tb_sram_dp_port_ctrl;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;
   logic          sram_csb0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic          sram_csb1;
   logic [AW-1:0] sram_addr1;
   logic [DW-1:0] sram_dout1;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] sram_mem [256];
   logic [DW-1:0] exp_mem  [256];
   logic [DW-1:0] exp_q [$];
   logic          hold_prev;
   logic [DW-1:0] hold_data;

   sram_dp_port_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RESP_DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Behavioural 256x32 macro, one cycle read latency.
   always @(posedge clock) begin
      if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
      if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: expected read data queued at accept, compared at response pop.
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("resp_hold_valid", resp_valid, 1);
            check("resp_hold_data", resp_data, hold_data);
         end
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("resp_spurious", DW'(exp_q.size()), 1);
            else                   check("resp_data", resp_data, exp_q.pop_front());
         end
         hold_prev = resp_valid && !resp_ready;
         hold_data = resp_data;
         if (rd_valid && rd_ready) exp_q.push_back(exp_mem[rd_addr]);
         if (wr_valid && wr_ready) exp_mem[wr_addr] = wr_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = '0;
         exp_mem[i]  = '0;
      end
      hold_prev  = 1'b0;
      hold_data  = '0;
      reset      = 1'b1;
      wr_valid   = 1'b1;
      wr_addr    = 8'h01;
      wr_data    = 32'h1111_1111;
      rd_valid   = 1'b1;
      rd_addr    = 8'h02;
      resp_ready = 1'b1;
      tick(); tick();
      @(negedge clock);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_ready", rd_ready, 0);
      check("rst_csb0", sram_csb0, 1);
      check("rst_csb1", sram_csb1, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      tick();

      // Write then read the same address on the next cycle.
      reset = 1'b0; rd_valid = 1'b0;
      wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 32'hDEAD_BEEF;
      @(negedge clock);
      check("t1_wr_ready", wr_ready, 1);
      check("t1_csb0_low", sram_csb0, 0);
      tick();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h10;
      @(negedge clock);
      check("t1_csb0_one_cycle", sram_csb0, 1);
      check("t1_csb1_low", sram_csb1, 0);
      tick();
      rd_valid = 1'b0;
      @(negedge clock);
      check("t1_resp_not_yet", resp_valid, 0);
      tick();
      @(negedge clock);
      check("t1_resp_valid", resp_valid, 1);
      check("t1_resp_data", resp_data, 32'hDEAD_BEEF);
      tick();

      // Same-cycle collision holds only the read.
      wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 32'h5A5A_5A5A;
      rd_valid = 1'b1; rd_addr = 8'h20;
      @(negedge clock);
      check("t2_wr_ready", wr_ready, 1);
      check("t2_rd_blocked", rd_ready, 0);
      check("t2_csb1_high", sram_csb1, 1);
      tick();
      wr_valid = 1'b0;
      @(negedge clock);
      check("t2_rd_retry", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      tick();
      @(negedge clock);
      check("t2_resp_valid", resp_valid, 1);
      check("t2_resp_data", resp_data, 32'h5A5A_5A5A);
      tick();

      // Preload 0..7 then stream 8 reads back to back.
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_addr = AW'(i); wr_data = DW'(i * 3);
         tick();
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_valid = 1'b1; rd_addr = AW'(i);
         @(negedge clock);
         check("t3_rd_ready", rd_ready, 1);
         check("t3_resp_timing", resp_valid, (i >= 2) ? 1 : 0);
         tick();
      end
      rd_valid = 1'b0;
      @(negedge clock);
      check("t3_resp_tail0", resp_valid, 1);
      tick();
      @(negedge clock);
      check("t3_resp_tail1", resp_valid, 1);
      tick();
      @(negedge clock);
      check("t3_resp_done", resp_valid, 0);
      tick();

      // Backpressure: credit admits exactly RESP_DEPTH reads.
      resp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         rd_valid = 1'b1; rd_addr = AW'(i);
         @(negedge clock);
         if (rd_ready) acc++;
         tick();
      end
      @(negedge clock);
      check("t4_accepted", DW'(acc), 4);
      check("t4_rd_ready_low", rd_ready, 0);
      check("t4_busy", busy, 1);
      tick();
      rd_valid = 1'b0; resp_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (resp_valid) acc++;
         tick();
      end
      check("t4_drained", DW'(acc), 4);
      rd_valid = 1'b1; rd_addr = 8'h03;
      @(negedge clock);
      check("t4_resume", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      tick(); tick(); tick();

      // Reset with one read in flight and two buffered.
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_valid = 1'b1; rd_addr = AW'(i + 4);
         tick();
      end
      rd_valid = 1'b0; reset = 1'b1;
      @(negedge clock);
      check("t5_busy_before", busy, 1);
      tick();
      reset = 1'b0; resp_ready = 1'b1;
      @(negedge clock);
      check("t5_resp_cleared", resp_valid, 0);
      check("t5_busy_cleared", busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clock);
         check("t5_no_late_resp", resp_valid, 0);
      end
      tick();

      // Top address plus enough traffic to wrap the FIFO pointers.
      wr_valid = 1'b1; wr_addr = 8'hFF; wr_data = 32'hCAFE_F00D;
      tick();
      for (int i = 0; i < 10; i++) begin
         wr_addr = AW'(8'h40 + i); wr_data = $urandom;
         rd_valid = 1'b1; rd_addr = (i == 0) ? 8'hFF : AW'(8'h40 + i - 1);
         tick();
      end
      wr_valid = 1'b0; rd_addr = 8'h49;
      tick();
      rd_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clock);
      check("t6_queue_empty", DW'(exp_q.size()), 0);
      check("t6_busy_idle", busy, 0);
      check("t6_resp_idle", resp_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_dp_port_ctrl.md
# sram_dp_port_ctrl

Requester-side controller for the 256x32 dual-port SRAM macro (port 0 write-only, port 1 read-only, active-low chip selects). It turns independent valid/ready write and read request streams from the datapath into SRAM port strobes. It also tracks read latency, captures returning read data into a response FIFO and exposes it on a valid/ready response stream. It blocks the same-cycle same-address read/write collision that the macro leaves undefined.

## Interface
- DATA_WIDTH, 32, word width; matches macro din0/dout1
- ADDR_WIDTH, 8, address width; matches macro addr0/addr1
- READ_LATENCY, 1, cycles from a read strobe (sram_csb1 low at a rising edge) to the rising edge that samples valid sram_dout1; range 1..4
- RESP_DEPTH, 4, response FIFO entries; must be >= READ_LATENCY+1

Ports:
- clock  in  1  single clock for the controller and both SRAM ports (clk0 = clk1 = clock)
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request ready
- rd_addr  in  ADDR_WIDTH  read address
- resp_valid  out  1  read response valid
- resp_ready  in  1  read response ready
- resp_data  out  DATA_WIDTH  read response data
- sram_csb0  out  1  macro port 0 chip select, active low
- sram_addr0  out  ADDR_WIDTH  macro port 0 address
- sram_din0  out  DATA_WIDTH  macro port 0 write data
- sram_csb1  out  1  macro port 1 chip select, active low
- sram_addr1  out  ADDR_WIDTH  macro port 1 address
- sram_dout1  in  DATA_WIDTH  macro port 1 read data
- busy  out  1  high while any read is in flight or buffered

## Operation
- Write fire: wr_fire = wr_valid & wr_ready. wr_ready = !reset. Writes never stall.
- sram_csb0 = !wr_fire. sram_addr0 = wr_addr and sram_din0 = wr_data, combinational pass-through.
- Collision: hazard = wr_fire & rd_valid & (rd_addr == wr_addr).
- Read credit: credit_ok = (fifo_count + inflight_count - pop) < RESP_DEPTH, where pop = resp_valid & resp_ready.
  - Arithmetic uses $clog2(RESP_DEPTH+1)+1 bits, so there is no underflow.
- Read ready: rd_ready = !reset & credit_ok & !hazard.
- Read fire: rd_fire = rd_valid & rd_ready. sram_csb1 = !rd_fire. sram_addr1 = rd_addr, pass-through.
- In-flight tracking: a READ_LATENCY-deep shift register of valid bits; stage 0 is loaded with rd_fire. inflight_count is the popcount of this register.
- Capture: when the last stage is 1, sram_dout1 is pushed into the FIFO at that edge.
- Response FIFO: circular buffer with wrapping read/write pointers.
  - resp_valid = fifo_count != 0; resp_data = entry at the head.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - The credit rule guarantees a push never meets a full FIFO.
- busy = (inflight_count != 0) | (fifo_count != 0).
- Ordering: responses return strictly in read-accept order.
- Write-then-read to one address: a read accepted in a later cycle than the write returns the new data.

## Timing
- Reset values, applied while reset is high and at the edge it is sampled:
  - wr_ready = 0, rd_ready = 0, sram_csb0 = 1, sram_csb1 = 1
  - resp_valid = 0, busy = 0; pipeline and FIFO pointers/count = 0
- Reset mid-operation: in-flight reads and buffered responses are discarded. sram_dout1 arriving after reset deasserts is ignored.
- Read latency: read fires in cycle N → data on sram_dout1 in cycle N+READ_LATENCY → captured at the end of that cycle → resp_valid in cycle N+READ_LATENCY+1. That is 2 cycles at default.
- Throughput: 1 read/cycle sustained when resp_ready is held high (requires RESP_DEPTH >= READ_LATENCY+1). 1 write/cycle always.
- Collision: only the read is held, for that cycle; the write proceeds. The read fires the next cycle if no new hazard.
- resp_data is stable while resp_valid & !resp_ready.

## Test plan
- Write 0xDEADBEEF to addr 0x10, read 0x10 next cycle → sram_csb0 low for exactly 1 cycle; resp_valid 2 cycles after rd_fire with resp_data = 0xDEADBEEF.
- Same cycle: write 0x5A5A5A5A to addr 0x20 and read addr 0x20 → wr_ready=1, rd_ready=0, sram_csb1 stays high. The read fires next cycle and returns 0x5A5A5A5A.
- Preload addr 0..7 with value = addr*3. Issue 8 back-to-back reads with resp_ready=1 → rd_ready never drops; responses 0,3,...,21 in order on 8 consecutive cycles.
- resp_ready=0 with reads requested continuously → exactly RESP_DEPTH (4) reads accepted, then rd_ready=0. Raise resp_ready → 4 responses drain in order, then reads resume.
- Assert reset for 1 cycle with 1 read in flight and 2 buffered → after reset resp_valid=0, busy=0; the late sram_dout1 value is never presented.
- Addr 0xFF write/read plus FIFO pointer wrap after 10 push/pop cycles → data correct, no dropped or duplicated responses.
